// File: rtl/f1_delay_timer.sv
// f1_delay_timer: random start delay and reaction timer for an F1-style
// start-lights game.
//
// A free-running 7-bit LFSR supplies the random part of the delay. A rising
// cmd_delay in IDLE loads lfsr + MIN_DELAY and counts it down on en ticks.
// On expiry time_out pulses and the reaction counter starts counting en ticks
// until the driver presses the button.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           timebase tick (one-cycle pulse); only timed counts use it
//   cmd_seq      light-sequence-active flag; a rising edge aborts any run
//   cmd_delay    delay request (level); its rising edge starts a run
//   button       driver button, synchronous to clk
//   time_out     one-cycle pulse: delay expired, lights go out
//   busy         high while in DELAY or TIMING
//   false_start  one-cycle pulse: button pressed during DELAY
//   react_valid  one-cycle pulse: reaction time captured
//   react_time   last captured reaction time in en ticks (saturating)
//   lfsr_out     current LFSR value

module f1_delay_timer #(
  parameter logic [7:0]  MIN_DELAY = 8'd16,
  parameter int unsigned REACT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cmd_seq,
  input  logic               cmd_delay,
  input  logic               button,
  output logic               time_out,
  output logic               busy,
  output logic               false_start,
  output logic               react_valid,
  output logic [REACT_W-1:0] react_time,
  output logic [6:0]         lfsr_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    TIMING = 2'd2
  } state_e;

  localparam logic [REACT_W-1:0] REACT_ONE = {{(REACT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [6:0]         lfsr_q, lfsr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [REACT_W-1:0] react_cnt_q, react_cnt_d;
  logic [REACT_W-1:0] react_time_q, react_time_d;
  logic               cmd_delay_q, button_q, cmd_seq_q;
  logic               time_out_q, time_out_d;
  logic               false_start_q, false_start_d;
  logic               react_valid_q, react_valid_d;
  logic               busy_q, busy_d;
  logic               start, press, seq_rise;

  assign start    = cmd_delay & ~cmd_delay_q;
  assign press    = button & ~button_q;
  assign seq_rise = cmd_seq & ~cmd_seq_q;

  // Taps 6 and 2 give a maximal-length sequence; the all-zero state is
  // unreachable from the non-zero reset seed.
  assign lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lfsr_q        <= 7'h01;
      cnt_q         <= '0;
      react_cnt_q   <= '0;
      react_time_q  <= '0;
      cmd_delay_q   <= 1'b0;
      button_q      <= 1'b0;
      cmd_seq_q     <= 1'b0;
      time_out_q    <= 1'b0;
      false_start_q <= 1'b0;
      react_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      cnt_q         <= cnt_d;
      react_cnt_q   <= react_cnt_d;
      react_time_q  <= react_time_d;
      cmd_delay_q   <= cmd_delay;
      button_q      <= button;
      cmd_seq_q     <= cmd_seq;
      time_out_q    <= time_out_d;
      false_start_q <= false_start_d;
      react_valid_q <= react_valid_d;
      busy_q        <= busy_d;
    end
  end

  // Next state and datapath. Priority in the active states is
  // seq_rise > press > en.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    react_cnt_d  = react_cnt_q;
    react_time_d = react_time_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = {1'b0, lfsr_q} + MIN_DELAY;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (seq_rise || press) begin
          state_d = IDLE;
        end else if (en) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d     = TIMING;
            react_cnt_d = '0;
          end
        end
      end
      TIMING: begin
        if (seq_rise) begin
          state_d = IDLE;
        end else if (press) begin
          // Capture the pre-increment count even if en coincides.
          react_time_d = react_cnt_q;
          state_d      = IDLE;
        end else if (en && (react_cnt_q != '1)) begin
          react_cnt_d = react_cnt_q + REACT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs decoded from the transition being taken.
  always_comb begin
    time_out_d    = (state_q == DELAY) && (state_d == TIMING);
    false_start_d = (state_q == DELAY) && press && !seq_rise;
    react_valid_d = (state_q == TIMING) && press && !seq_rise;
    busy_d        = (state_d != IDLE);
  end

  assign time_out    = time_out_q;
  assign busy        = busy_q;
  assign false_start = false_start_q;
  assign react_valid = react_valid_q;
  assign react_time  = react_time_q;
  assign lfsr_out    = lfsr_q;

endmodule

// File: tb/tb_f1_delay_timer.sv
// Testbench for f1_delay_timer: directed scenarios plus randomized runs.
// Expected LFSR values come from a table built with the recurrence; expected
// delays and reaction times come from counting the en ticks the bench issues.

module tb_f1_delay_timer;

  localparam int MIN_D = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, cmd_seq = 1'b0, cmd_delay = 1'b0, button = 1'b0;
  logic        time_out, busy, false_start, react_valid;
  logic [15:0] react_time;
  logic [6:0]  lfsr_out;
  logic        time_out_w4, busy_w4, false_start_w4, react_valid_w4;
  logic [3:0]  react_time_w4;
  logic [6:0]  lfsr_out_w4;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0]  seq [127];
  int unsigned cyc;
  int          n_to, n_fs, n_rv, en_ticks, to_at;
  int          exp_rt = 0;
  int          exp_rt_w4 = 0;

  f1_delay_timer dut (
    .clk(clk), .rst(rst), .en(en), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay),
    .button(button), .time_out(time_out), .busy(busy),
    .false_start(false_start), .react_valid(react_valid),
    .react_time(react_time), .lfsr_out(lfsr_out)
  );

  f1_delay_timer #(.REACT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .en(en), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay),
    .button(button), .time_out(time_out_w4), .busy(busy_w4),
    .false_start(false_start_w4), .react_valid(react_valid_w4),
    .react_time(react_time_w4), .lfsr_out(lfsr_out_w4)
  );

  always #5 clk = ~clk;

  // Clock cycles since reset release: indexes the reference LFSR table.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic clr_obs();
    n_to = 0; n_fs = 0; n_rv = 0; en_ticks = 0; to_at = -1;
  endtask

  // One clock: drive en/button, pass the edge, record output pulses.
  task automatic cycle(input logic e, input logic b);
    en = e;
    button = b;
    @(posedge clk);
    #1;
    if (e) en_ticks++;
    if (time_out) begin
      n_to++;
      if (n_to == 1) to_at = en_ticks;
    end
    if (false_start) n_fs++;
    if (react_valid) n_rv++;
    en = 1'b0;
    button = 1'b0;
  endtask

  task automatic run_ens(input int n, input int gmin, input int gmax);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gmax, gmin)) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
    end
  endtask

  // Raise cmd_delay for the next edge; returns the delay the design should load.
  task automatic start_delay(input bit hold, output int n);
    logic [6:0] l;
    l = seq[cyc % 127];
    cmd_delay = 1'b1;
    cycle(1'b0, 1'b0);
    if (!hold) cmd_delay = 1'b0;
    n = int'(l) + MIN_D;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0; button = 1'b0; cmd_delay = 1'b0; cmd_seq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rt = 0;
    exp_rt_w4 = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (lfsr_out !== 7'h01) begin n_errors++; $display("FAIL reset_lfsr: got %h expected 01", lfsr_out); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if ({time_out, false_start, react_valid} !== 3'b000) begin n_errors++; $display("FAIL reset_pulses: got %b expected 000", {time_out, false_start, react_valid}); end
    n_checks++; if (react_time !== 16'd0) begin n_errors++; $display("FAIL reset_react_time: got %0d expected 0", react_time); end
    n_checks++; if (react_time_w4 !== 4'd0) begin n_errors++; $display("FAIL reset_react_time_w4: got %0d expected 0", react_time_w4); end
    rst = 1'b0;
  endtask

  task automatic test_lfsr();
    logic [6:0] exp7 [7];
    exp7 = '{7'h01, 7'h02, 7'h04, 7'h09, 7'h12, 7'h24, 7'h49};
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (lfsr_out !== exp7[i]) begin n_errors++; $display("FAIL lfsr_start[%0d]: got %h expected %h", i, lfsr_out, exp7[i]); end
      cycle(1'b0, 1'b0);
    end
    for (int i = 0; i < 128; i++) begin
      n_checks++; if (lfsr_out === 7'h00) begin n_errors++; $display("FAIL lfsr_nonzero[%0d]: got 00 expected nonzero", i); end
      n_checks++; if (lfsr_out !== seq[cyc % 127]) begin n_errors++; $display("FAIL lfsr_period[%0d]: got %h expected %h", i, lfsr_out, seq[cyc % 127]); end
      cycle(1'b0, 1'b0);
    end
  endtask

  task automatic test_delay_expire();
    int n;
    int guard;
    do_reset();
    guard = 0;
    while (seq[cyc % 127] != 7'h04 && guard < 127) begin
      cycle(1'b0, 1'b0);
      guard++;
    end
    start_delay(1'b0, n);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL delay_busy: got %b expected 1", busy); end
    clr_obs();
    run_ens(19, 3, 3);
    n_checks++; if (n_to != 0) begin n_errors++; $display("FAIL delay_early_timeout: got %0d pulses expected 0", n_to); end
    run_ens(1, 3, 3);
    n_checks++; if (time_out !== 1'b1) begin n_errors++; $display("FAIL delay_timeout_20: got %b expected 1", time_out); end
    n_checks++; if (to_at != 20) begin n_errors++; $display("FAIL delay_timeout_tick: got %0d expected 20", to_at); end
    cycle(1'b0, 1'b0);
    n_checks++; if (time_out !== 1'b0) begin n_errors++; $display("FAIL delay_timeout_width: got %b expected 0", time_out); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL timing_busy: got %b expected 1", busy); end
  endtask

  task automatic test_reaction();
    clr_obs();
    run_ens(37, 0, 3);
    cycle(1'b0, 1'b1);
    n_checks++; if (react_valid !== 1'b1) begin n_errors++; $display("FAIL react_valid: got %b expected 1", react_valid); end
    n_checks++; if (react_time !== 16'd37) begin n_errors++; $display("FAIL react_time: got %0d expected 37", react_time); end
    n_checks++; if (react_time_w4 !== 4'd15) begin n_errors++; $display("FAIL react_time_w4: got %0d expected 15", react_time_w4); end
    cycle(1'b0, 1'b0);
    n_checks++; if (react_valid !== 1'b0 || n_rv != 1) begin n_errors++; $display("FAIL react_valid_width: got %0d pulses expected 1", n_rv); end
    n_checks++; if (busy !== 1'b0 || busy_w4 !== 1'b0) begin n_errors++; $display("FAIL react_busy: got %b/%b expected 0/0", busy, busy_w4); end
    exp_rt = 37;
    exp_rt_w4 = 15;
  endtask

  task automatic test_false_start();
    int n, k;
    for (int it = 0; it < 3; it++) begin
      start_delay(1'b0, n);
      clr_obs();
      k = $urandom_range(n - 2, 0);
      run_ens(k, 0, 2);
      cycle(1'b0, 1'b1);
      n_checks++; if (false_start !== 1'b1) begin n_errors++; $display("FAIL false_start[%0d]: got %b expected 1", it, false_start); end
      cycle(1'b0, 1'b0);
      n_checks++; if (false_start !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL false_start_after[%0d]: got fs=%b busy=%b expected 0 0", it, false_start, busy); end
      run_ens(n + 3, 0, 1);
      n_checks++; if (n_to != 0 || n_rv != 0 || n_fs != 1) begin n_errors++; $display("FAIL false_start_pulses[%0d]: got to=%0d rv=%0d fs=%0d expected 0 0 1", it, n_to, n_rv, n_fs); end
      n_checks++; if (react_time !== 16'(exp_rt)) begin n_errors++; $display("FAIL false_start_keep[%0d]: got %0d expected %0d", it, react_time, exp_rt); end
    end
  endtask

  task automatic test_press_en_tie();
    int n;
    start_delay(1'b0, n);
    clr_obs();
    run_ens(n - 1, 0, 1);
    cycle(1'b1, 1'b1);
    n_checks++; if (false_start !== 1'b1 || time_out !== 1'b0) begin n_errors++; $display("FAIL tie_press_wins: got fs=%b to=%b expected 1 0", false_start, time_out); end
    cycle(1'b0, 1'b0);
    n_checks++; if (busy !== 1'b0 || n_to != 0) begin n_errors++; $display("FAIL tie_idle: got busy=%b to=%0d expected 0 0", busy, n_to); end
  endtask

  task automatic test_seq_abort();
    int n;
    start_delay(1'b0, n);
    clr_obs();
    run_ens(n, 0, 1);
    run_ens(5, 0, 1);
    cmd_seq = 1'b1;
    cycle(1'b1, 1'b1);
    n_checks++; if ({react_valid, false_start} !== 2'b00) begin n_errors++; $display("FAIL seq_abort_timing_pulses: got rv=%b fs=%b expected 0 0", react_valid, false_start); end
    cycle(1'b0, 1'b0);
    cmd_seq = 1'b0;
    n_checks++; if (busy !== 1'b0 || react_time !== 16'(exp_rt) || n_rv != 0) begin n_errors++; $display("FAIL seq_abort_timing_idle: got busy=%b rt=%0d rv=%0d expected 0 %0d 0", busy, react_time, n_rv, exp_rt); end
    cycle(1'b0, 1'b0);
    start_delay(1'b0, n);
    clr_obs();
    run_ens(n - 1, 0, 1);
    cmd_seq = 1'b1;
    cycle(1'b1, 1'b0);
    n_checks++; if (time_out !== 1'b0) begin n_errors++; $display("FAIL seq_abort_delay_to: got %b expected 0", time_out); end
    run_ens(n + 2, 0, 1);
    cmd_seq = 1'b0;
    n_checks++; if (busy !== 1'b0 || n_to != 0 || n_fs != 0) begin n_errors++; $display("FAIL seq_abort_delay_idle: got busy=%b to=%0d fs=%0d expected 0 0 0", busy, n_to, n_fs); end
  endtask

  task automatic test_cmd_held();
    int n, r;
    start_delay(1'b1, n);
    clr_obs();
    run_ens(n, 0, 1);
    n_checks++; if (n_to != 1 || to_at != n) begin n_errors++; $display("FAIL held_single_load: got to=%0d at tick %0d expected 1 at %0d", n_to, to_at, n); end
    r = $urandom_range(30, 5);
    run_ens(r, 0, 1);
    cycle(1'b0, 1'b1);
    n_checks++; if (react_time !== 16'(r)) begin n_errors++; $display("FAIL held_react: got %0d expected %0d", react_time, r); end
    exp_rt = r;
    exp_rt_w4 = sat4(r);
    repeat (10) cycle(1'b1, 1'b0);
    n_checks++; if (busy !== 1'b0 || n_to != 1) begin n_errors++; $display("FAIL held_no_reload: got busy=%b to=%0d expected 0 1", busy, n_to); end
    cmd_delay = 1'b0;
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    int n;
    start_delay(1'b0, n);
    clr_obs();
    run_ens(n, 0, 1);
    run_ens(20, 0, 2);
    cycle(1'b0, 1'b1);
    n_checks++; if (react_time_w4 !== 4'd15) begin n_errors++; $display("FAIL saturate_w4: got %0d expected 15", react_time_w4); end
    n_checks++; if (react_time !== 16'd20) begin n_errors++; $display("FAIL saturate_w16: got %0d expected 20", react_time); end
    exp_rt = 20;
    exp_rt_w4 = 15;
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    start_delay(1'b0, n);
    run_ens(5, 0, 1);
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || lfsr_out !== 7'h01 || react_time !== 16'd0) begin n_errors++; $display("FAIL reset_mid_delay: got busy=%b lfsr=%h rt=%0d expected 0 01 0", busy, lfsr_out, react_time); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rt = 0;
    exp_rt_w4 = 0;
    clr_obs();
    run_ens(40, 0, 1);
    n_checks++; if (busy !== 1'b0 || n_to != 0 || n_fs != 0 || n_rv != 0) begin n_errors++; $display("FAIL reset_mid_delay_release: got busy=%b to=%0d fs=%0d rv=%0d expected all 0", busy, n_to, n_fs, n_rv); end
    start_delay(1'b0, n);
    run_ens(n, 0, 1);
    run_ens(3, 0, 1);
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || time_out !== 1'b0) begin n_errors++; $display("FAIL reset_mid_timing: got busy=%b to=%b expected 0 0", busy, time_out); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_obs();
    cycle(1'b1, 1'b1);
    run_ens(10, 0, 1);
    n_checks++; if (n_rv != 0 || n_to != 0 || n_fs != 0 || react_time !== 16'd0) begin n_errors++; $display("FAIL reset_mid_timing_release: got rv=%0d to=%0d fs=%0d rt=%0d expected 0 0 0 0", n_rv, n_to, n_fs, react_time); end
  endtask

  task automatic test_random();
    int n, k, r, g;
    logic pe;
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(20, 0)) cycle(1'($urandom_range(1, 0)), 1'b0);
      start_delay(1'($urandom_range(1, 0)), n);
      clr_obs();
      if ($urandom_range(3, 0) == 0) begin
        k = $urandom_range(n - 1, 0);
        run_ens(k, 0, 2);
        cycle(1'b0, 1'b1);
        n_checks++; if (false_start !== 1'b1 || n_to != 0) begin n_errors++; $display("FAIL rand_false_start[%0d]: got fs=%b to=%0d expected 1 0", it, false_start, n_to); end
      end else begin
        g = $urandom_range(2, 0);
        run_ens(n, 0, g);
        n_checks++; if (n_to != 1 || to_at != n) begin n_errors++; $display("FAIL rand_delay[%0d]: got to=%0d at tick %0d expected 1 at %0d", it, n_to, to_at, n); end
        r = $urandom_range(40, 0);
        run_ens(r, 0, 2);
        pe = 1'($urandom_range(1, 0));
        cycle(pe, 1'b1);
        exp_rt = r;
        exp_rt_w4 = sat4(r);
        n_checks++; if (react_valid !== 1'b1 || react_time !== 16'(exp_rt) || react_time_w4 !== 4'(exp_rt_w4)) begin n_errors++; $display("FAIL rand_react[%0d]: got rv=%b rt=%0d rt4=%0d expected 1 %0d %0d", it, react_valid, react_time, react_time_w4, exp_rt, exp_rt_w4); end
      end
      cmd_delay = 1'b0;
      cycle(1'b0, 1'b0);
      n_checks++; if (busy !== 1'b0 || react_time !== 16'(exp_rt)) begin n_errors++; $display("FAIL rand_idle[%0d]: got busy=%b rt=%0d expected 0 %0d", it, busy, react_time, exp_rt); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    seq[0] = 7'h01;
    for (int i = 1; i < 127; i++) seq[i] = {seq[i-1][5:0], seq[i-1][6] ^ seq[i-1][2]};
    test_reset();
    test_lfsr();
    test_delay_expire();
    test_reaction();
    test_false_start();
    test_press_en_tie();
    test_seq_abort();
    test_cmd_held();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
